// File: rtl/affine_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : affine_pipe
//  Description : 4-stage signed affine pipeline with ready/valid handshake.
//                Y = red((red(red(X*A) + B)) * C + D), where red() either
//                clamps (SAT=1) or wraps (SAT=0) to WIDTH bits. A per-sample
//                overflow flag records whether any reduction changed a value.
//  Revision    : 1.0  initial release
// ============================================================================
module affine_pipe #(
    parameter int WIDTH = 16,
    parameter int A     = 3,
    parameter int B     = 5,
    parameter int C     = 2,
    parameter int D     = 7,
    parameter int SAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] X,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] Y,
    output logic                    ovf
);

    // Every intermediate is carried at 2*WIDTH+1 bits: wide enough for the
    // full product plus one carry bit from the following addend.
    localparam int c_ext_w = 2 * WIDTH + 1;

    localparam logic signed [c_ext_w-1:0] c_a_ext = c_ext_w'(A);
    localparam logic signed [c_ext_w-1:0] c_b_ext = c_ext_w'(B);
    localparam logic signed [c_ext_w-1:0] c_c_ext = c_ext_w'(C);
    localparam logic signed [c_ext_w-1:0] c_d_ext = c_ext_w'(D);
    localparam logic signed [c_ext_w-1:0] c_max_val =
        {{(WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [c_ext_w-1:0] c_min_val =
        {{(WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};

    // Reduce a wide value to WIDTH bits; MSB of the result is "value changed".
    function automatic logic [WIDTH:0] f_reduce(input logic signed [c_ext_w-1:0] v);
        logic signed [WIDTH-1:0] r;
        logic                    chg;
        r   = v[WIDTH-1:0];
        chg = 1'b0;
        if (SAT != 0) begin
            if (v > c_max_val) begin
                r   = c_max_val[WIDTH-1:0];
                chg = 1'b1;
            end else if (v < c_min_val) begin
                r   = c_min_val[WIDTH-1:0];
                chg = 1'b1;
            end
        end else begin
            chg = ({{(WIDTH + 1){r[WIDTH-1]}}, r} != v);
        end
        return {chg, r};
    endfunction

    // Stage registers, index 1..4 (stage 4 drives the outputs)
    logic [4:1]              v_q, v_d;
    logic [4:1]              o_q, o_d;
    logic signed [WIDTH-1:0] d_q [1:4];
    logic signed [WIDTH-1:0] d_d [1:4];

    // Per-stage combinational inputs
    logic [4:1]              w_vin;
    logic [4:1]              w_ovf;
    logic signed [WIDTH-1:0] w_val [1:4];
    logic [4:1]              w_rdy;
    logic                    w_rdy1, w_rdy2, w_rdy3, w_rdy4;

    logic signed [c_ext_w-1:0] w_s1_full, w_s2_full, w_s3_full;
    logic signed [c_ext_w-1:0] w_x_ext, w_d1_ext, w_d2_ext;
    logic [WIDTH:0]            w_s1_red, w_s2_red, w_s3_red;

    // Ready ripples back from the consumer; a stage is free if empty or draining
    always_comb begin
        w_rdy4 = !v_q[4] || out_ready;
        w_rdy3 = !v_q[3] || w_rdy4;
        w_rdy2 = !v_q[2] || w_rdy3;
        w_rdy1 = !v_q[1] || w_rdy2;
        w_rdy  = {w_rdy4, w_rdy3, w_rdy2, w_rdy1};
    end

    // Arithmetic for each stage, computed from the previous stage's register
    always_comb begin
        w_x_ext   = {{(WIDTH + 1){X[WIDTH-1]}}, X};
        w_d1_ext  = {{(WIDTH + 1){d_q[1][WIDTH-1]}}, d_q[1]};
        w_d2_ext  = {{(WIDTH + 1){d_q[2][WIDTH-1]}}, d_q[2]};
        w_s1_full = w_x_ext * c_a_ext;
        w_s2_full = w_d1_ext + c_b_ext;
        w_s3_full = w_d2_ext * c_c_ext + c_d_ext;
        w_s1_red  = f_reduce(w_s1_full);
        w_s2_red  = f_reduce(w_s2_full);
        w_s3_red  = f_reduce(w_s3_full);

        w_vin    = {v_q[3], v_q[2], v_q[1], in_valid};
        w_val[1] = w_s1_red[WIDTH-1:0];
        w_val[2] = w_s2_red[WIDTH-1:0];
        w_val[3] = w_s3_red[WIDTH-1:0];
        w_val[4] = d_q[3];
        w_ovf[1] = w_s1_red[WIDTH];
        w_ovf[2] = o_q[1] | w_s2_red[WIDTH];
        w_ovf[3] = o_q[2] | w_s3_red[WIDTH];
        w_ovf[4] = o_q[3];
    end

    // Next-state: a ready stage takes the upstream valid; data only moves with a valid
    always_comb begin
        v_d = v_q;
        o_d = o_q;
        d_d = d_q;
        for (int k = 1; k <= 4; k++) begin
            if (w_rdy[k]) begin
                v_d[k] = w_vin[k];
                if (w_vin[k]) begin
                    d_d[k] = w_val[k];
                    o_d[k] = w_ovf[k];
                end
            end
        end
    end

    // Stage registers; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            o_q <= '0;
            for (int k = 1; k <= 4; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            o_q <= o_d;
            d_q <= d_d;
        end
    end

    assign in_ready  = w_rdy1;
    assign out_valid = v_q[4];
    assign Y         = d_q[4];
    assign ovf       = o_q[4];

endmodule
`default_nettype wire

// File: tb/tb_affine_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_affine_pipe
//  Description : Scoreboard bench for affine_pipe. Three instances with
//                different coefficients / modes share one stimulus stream;
//                a reference model computes each expected result.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_affine_pipe;

    typedef struct packed {
        logic signed [15:0] y;
        logic               o;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic signed [15:0] x_in = '0;
    logic              out_ready = 1'b1;
    logic              in_rdy [3];
    logic              ov     [3];
    logic signed [15:0] yv    [3];
    logic              of     [3];

    int checks   = 0;
    int failures = 0;
    int or_mode  = 0;   // 0: always ready, 1: never ready, 2: random

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    affine_pipe #(.WIDTH(16), .A(3), .B(5), .C(2), .D(7), .SAT(1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]), .X(x_in),
        .out_valid(ov[0]), .out_ready(out_ready), .Y(yv[0]), .ovf(of[0]));
    affine_pipe #(.WIDTH(16), .A(3), .B(5), .C(2), .D(7), .SAT(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]), .X(x_in),
        .out_valid(ov[1]), .out_ready(out_ready), .Y(yv[1]), .ovf(of[1]));
    affine_pipe #(.WIDTH(16), .A(-1), .B(-100), .C(-3), .D(1000), .SAT(0)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]), .X(x_in),
        .out_valid(ov[2]), .out_ready(out_ready), .Y(yv[2]), .ovf(of[2]));

    // ---------------- reference model ----------------
    function automatic longint red16(input longint v, input int sat, output bit chg);
        longint r;
        if (sat != 0) begin
            r = (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
        end else begin
            r = v & 64'hFFFF;
            if (r > 32767) r = r - 65536;
        end
        chg = (r != v);
        return r;
    endfunction

    function automatic exp_t model(input longint x, input int a, input int b,
                                   input int c, input int d, input int sat);
        longint s1, s2, s3;
        bit     c1, c2, c3;
        exp_t   e;
        s1  = red16(x * a, sat, c1);
        s2  = red16(s1 + b, sat, c2);
        s3  = red16(s2 * c + d, sat, c3);
        e.y = 16'(s3);
        e.o = c1 | c2 | c3;
        return e;
    endfunction

    task automatic cmp(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- consumer ready driver ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (or_mode == 0)      out_ready = 1'b1;
            else if (or_mode == 1) out_ready = 1'b0;
            else                   out_ready = ($urandom_range(0, 9) < 6);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic pop_check(input int k);
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output dut%0d actual=%0d required=none", k, yv[k]);
        end else begin
            cmp($sformatf("Y_dut%0d", k), yv[k], e.y);
            cmp($sformatf("ovf_dut%0d", k), of[k], e.o);
        end
    endtask

    initial begin
        bit              held [3];
        logic signed [15:0] hy [3];
        logic            ho [3];
        for (int k = 0; k < 3; k++) begin held[k] = 0; hy[k] = '0; ho[k] = 0; end
        forever begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    held[k] = 0;
                end else begin
                    if (held[k]) begin
                        cmp($sformatf("hold_valid_dut%0d", k), ov[k], 1);
                        cmp($sformatf("hold_Y_dut%0d", k), yv[k], hy[k]);
                        cmp($sformatf("hold_ovf_dut%0d", k), of[k], ho[k]);
                    end
                    if (ov[k] && out_ready) pop_check(k);
                    held[k] = ov[k] && !out_ready;
                    hy[k]   = yv[k];
                    ho[k]   = of[k];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic signed [15:0] x);
        int  n;
        bit  acc;
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = x;
        #1;
        acc = in_rdy[0];
        n   = 0;
        while (!acc && n < 500) begin
            @(negedge clk);
            #1;
            acc = in_rdy[0];
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=accept");
            return;
        end
        @(posedge clk);
        q0.push_back(model(x, 3, 5, 2, 7, 1));
        q1.push_back(model(x, 3, 5, 2, 7, 0));
        q2.push_back(model(x, -1, -100, -3, 1000, 0));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        or_mode = 0;
        idle();
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        cmp("drain_pending", q0.size() + q1.size() + q2.size(), 0);
    endtask

    // Cycles from the in_valid cycle of the last send() to the first out_valid cycle
    task automatic measure_latency(input int req);
        int lat;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) in_valid = 1'b0;
            #1;
            if (ov[0] && lat < 0) lat = k + 1;
        end
        cmp("latency", lat, req);
    endtask

    initial begin
        logic [31:0]        rnd;
        logic signed [15:0] xr;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            cmp($sformatf("rst_valid_dut%0d", k), ov[k], 0);
            cmp($sformatf("rst_Y_dut%0d", k), yv[k], 0);
            cmp($sformatf("rst_ovf_dut%0d", k), of[k], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        cmp("in_ready_after_rst", in_rdy[0], 1);

        // Single pulse, latency
        or_mode = 0;
        send(16'sd10);
        measure_latency(4);

        // Directed values, then a back-to-back stream
        send(-16'sd4);
        for (int i = 0; i < 10; i++) send(16'(i));
        send(16'sd20000);
        send(16'sd1);
        send(-16'sd32768);
        send(16'sd32767);
        drain();

        // Fill with a stalled consumer
        or_mode = 1;
        for (int i = 1; i <= 4; i++) send(16'(i));
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = 16'sd5;
        #1;
        cmp("full_in_ready", in_rdy[0], 0);
        cmp("full_Y", yv[0], 23);
        repeat (3) begin
            @(negedge clk);
            #1;
            cmp("full_hold_in_ready", in_rdy[0], 0);
            cmp("full_hold_Y", yv[0], 23);
        end
        or_mode = 0;
        send(16'sd5);
        send(16'sd6);
        drain();

        // Reset with samples in flight
        send(16'sd100);
        send(16'sd200);
        send(16'sd300);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            cmp($sformatf("midrst_valid_dut%0d", k), ov[k], 0);
            cmp($sformatf("midrst_Y_dut%0d", k), yv[k], 0);
            cmp($sformatf("midrst_ovf_dut%0d", k), of[k], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        cmp("in_ready_after_midrst", in_rdy[0], 1);
        send(16'sd10);
        measure_latency(4);
        drain();

        // Random traffic with random backpressure
        or_mode = 2;
        for (int i = 0; i < 300; i++) begin
            rnd = $urandom();
            case ($urandom_range(0, 9))
                0:       xr = -16'sd32768;
                1:       xr = 16'sd32767;
                2:       xr = 16'($signed(rnd[7:0]));
                default: xr = rnd[15:0];
            endcase
            send(xr);
            if ($urandom_range(0, 3) == 0) idle();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
